sub_fp_seq: RTL

//   Multi-cycle IEEE-754-style floating-point subtractor: res_sub = a - b. It is the

---
 rtl/sub_fp_seq_pkg.sv | 18 +
 rtl/sub_fp_seq_unpack.sv | 18 +
 rtl/sub_fp_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sub_fp_seq_pkg.sv
// Shared definitions for the sequential floating-point subtractor:
// FSM state encodings and NZCV flag bit positions.
package sub_fp_seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ALIGN = 3'd1,
      OP    = 3'd2,
      NORM  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/sub_fp_seq_unpack.sv
// Splits a packed float into sign, biased exponent and {carry, hidden 1, fraction}.
// The neg input flips the sign so the subtrahend can be fed in already negated.
module fp_unpack #(
   parameter int MANTISA_WIDTH  = 23,
   parameter int EXPONENT_WIDTH = 8
) (
   input  logic [MANTISA_WIDTH+EXPONENT_WIDTH:0] word,
   input  logic                                  neg,
   output logic                                  sign,
   output logic [EXPONENT_WIDTH-1:0]             exp,
   output logic [MANTISA_WIDTH+1:0]              mant
);

   assign sign = word[MANTISA_WIDTH+EXPONENT_WIDTH] ^ neg;
   assign exp  = word[MANTISA_WIDTH+EXPONENT_WIDTH-1:MANTISA_WIDTH];
   assign mant = {2'b01, word[MANTISA_WIDTH-1:0]};

endmodule

// File: rtl/sub_fp_seq.sv
// Multi-cycle floating-point subtractor a - b with NZCV flags; alignment and
// renormalisation advance one bit per clock under a start/done handshake.
module sub_fp_seq
   import sub_fp_seq_pkg::*;
#(
   parameter int MANTISA_WIDTH  = 23,
   parameter int EXPONENT_WIDTH = 8
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic                                  start,
   input  logic [MANTISA_WIDTH+EXPONENT_WIDTH:0] a,
   input  logic [MANTISA_WIDTH+EXPONENT_WIDTH:0] b,
   output logic                                  busy,
   output logic                                  done,
   output logic [MANTISA_WIDTH+EXPONENT_WIDTH:0] res_sub,
   output logic [3:0]                            flags_sub
);

   localparam int M  = MANTISA_WIDTH;
   localparam int E  = EXPONENT_WIDTH;
   localparam int W  = M + E + 1;
   localparam int CW = $clog2(M + 3);

   state_t          state, state_nx;
   logic            sa, sb, sgn, cy, shift_a;
   logic [M+1:0]    ma, mb, sum, op_sum;
   logic [E:0]      ex;
   logic [CW-1:0]   cnt, kval;
   logic            op_sign, norm_exit;
   logic            ua_s, ub_s;
   logic [E-1:0]    ua_e, ub_e, diff;
   logic [M+1:0]    ua_m, ub_m;

   fp_unpack #(.MANTISA_WIDTH(M), .EXPONENT_WIDTH(E)) u_unpack_a (
      .word(a), .neg(1'b0), .sign(ua_s), .exp(ua_e), .mant(ua_m));

   fp_unpack #(.MANTISA_WIDTH(M), .EXPONENT_WIDTH(E)) u_unpack_b (
      .word(b), .neg(1'b1), .sign(ub_s), .exp(ub_e), .mant(ub_m));

   // Overflow saturates to Inf; cancellation or exponent underflow flushes to +0.
   function automatic logic [W+3:0] pack_result(input logic s, input logic [E:0] e,
                                                input logic [M:0] m, input logic c);
      logic [W-1:0] r;
      logic [3:0]   f;
      logic         v;
      v = 1'b0;
      if (e[E] || (&e[E-1:0])) begin
         v = 1'b1;
         r = {s, {E{1'b1}}, {M{1'b0}}};
      end else if (m == '0 || (e[E-1:0] == '0 && !m[M])) begin
         r = '0;
      end else begin
         r = {s, e[E-1:0], m[M-1:0]};
      end
      f         = '0;
      f[FLAG_N] = r[W-1];
      f[FLAG_Z] = (r[W-2:0] == '0);
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return {r, f};
   endfunction

   always_comb begin
      diff = (ua_e > ub_e) ? (ua_e - ub_e) : (ub_e - ua_e);
      kval = (int'(diff) > M + 2) ? CW'(M + 2) : CW'(diff);
   end

   always_comb begin
      op_sum  = '0;
      op_sign = sa;
      if (sa == sb) begin
         op_sum = ma + mb;
      end else if (ma >= mb) begin
         op_sum = ma - mb;
      end else begin
         op_sum  = mb - ma;
         op_sign = sb;
      end
   end

   assign norm_exit = sum[M] || (sum == '0) || (ex == '0);

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = (state != IDLE);
      done     = 1'b0;
      case (state)
         IDLE:    if (start) state_nx = ALIGN;
         ALIGN:   if (cnt == '0) state_nx = OP;
         OP:      state_nx = NORM;
         NORM:    if (norm_exit) state_nx = DONE;
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      case (state)
         IDLE: if (start) begin
            sa      <= ua_s;
            sb      <= ub_s;
            ma      <= ua_m;
            mb      <= ub_m;
            shift_a <= (ua_e < ub_e);
            ex      <= {1'b0, (ua_e > ub_e) ? ua_e : ub_e};
            cnt     <= kval;
         end
         ALIGN: if (cnt != '0) begin
            if (shift_a) ma <= ma >> 1;
            else         mb <= mb >> 1;
            cnt <= cnt - 1'b1;
         end
         OP: begin
            sgn <= op_sign;
            if (op_sum[M+1]) begin
               cy  <= 1'b1;
               sum <= op_sum >> 1;
               ex  <= ex + 1'b1;
            end else begin
               cy  <= 1'b0;
               sum <= op_sum;
            end
         end
         NORM: if (!norm_exit) begin
            sum <= sum << 1;
            ex  <= ex - 1'b1;
         end
         default: ;
      endcase
   end

   // Result is captured on the edge that enters DONE so it is valid alongside the pulse.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         res_sub   <= '0;
         flags_sub <= '0;
      end else if (state == NORM && norm_exit) begin
         {res_sub, flags_sub} <= pack_result(sgn, ex, sum[M:0], cy);
      end
   end

endmodule
